// File: rtl/player_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : player_input_conditioner_if
// Brief    : Raw controller pins in, debounced and frame-aligned button state out.
// Revision : 1.0
// ============================================================================
interface player_input_conditioner_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 6
);
    localparam int WIDTH = NUM_PLAYERS * NUM_BUTTONS;

    logic             frame_tick;
    logic [WIDTH-1:0] raw_buttons;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] frame_level;
    logic [WIDTH-1:0] frame_press;
    logic             frame_valid;

    // master: board / game side that owns the pins and the frame timing
    modport master (
        output frame_tick, raw_buttons,
        input  level, frame_level, frame_press, frame_valid
    );

    modport slave (
        input  frame_tick, raw_buttons,
        output level, frame_level, frame_press, frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/player_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : player_input_conditioner
// Brief    : N-player, M-button synchroniser, debouncer and per-frame press latch.
// Revision : 1.0
// ============================================================================
module player_input_conditioner #(
    parameter int                     NUM_PLAYERS     = 2,
    parameter int                     NUM_BUTTONS     = 6,
    parameter int                     DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [NUM_BUTTONS-1:0] ACTIVE_LOW_MASK = 6'b001111
) (
    input wire logic                  clk,
    input wire logic                  rst_l,
    player_input_conditioner_if.slave bus
);

    localparam int              WIDTH    = NUM_PLAYERS * NUM_BUTTONS;
    localparam logic [WIDTH-1:0] POL_MASK = {NUM_PLAYERS{ACTIVE_LOW_MASK}};
    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_b;
    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] deb_level;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] snap_level;
    logic [WIDTH-1:0] snap_press;
    logic             valid_pulse;

    // Synchroniser resets to the released pin value so norm starts at 0
    // and reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_a <= POL_MASK;
            sync_b <= POL_MASK;
        end else begin
            sync_a <= bus.raw_buttons;
            sync_b <= sync_a;
        end
    end

    assign norm = sync_b ^ POL_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                cnt <= '0;
            end else if (norm[i] == deb_level[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level_next[i] = ((norm[i] != deb_level[i]) && (cnt == CNT_MAX))
                               ? norm[i] : deb_level[i];
    end

    assign rise = level_next & ~deb_level;

    // A rise landing on the tick edge belongs to the closing frame only.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            deb_level   <= '0;
            pend        <= '0;
            snap_level  <= '0;
            snap_press  <= '0;
            valid_pulse <= 1'b0;
        end else begin
            deb_level   <= level_next;
            valid_pulse <= bus.frame_tick;
            if (bus.frame_tick) begin
                snap_level <= level_next;
                snap_press <= pend | rise;
                pend       <= '0;
            end else begin
                pend       <= pend | rise;
            end
        end
    end

    assign bus.level       = deb_level;
    assign bus.frame_level = snap_level;
    assign bus.frame_press = snap_press;
    assign bus.frame_valid = valid_pulse;

endmodule
`default_nettype wire

// File: tb/tb_player_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_input_conditioner
// Brief    : Scoreboard bench for player_input_conditioner (DEBOUNCE_CYCLES = 4).
// Revision : 1.0
// ============================================================================
module tb_player_input_conditioner;

    localparam int          NUM_PLAYERS = 2;
    localparam int          NUM_BUTTONS = 6;
    localparam int          WIDTH       = NUM_PLAYERS * NUM_BUTTONS;
    localparam logic [11:0] IDLE        = 12'b001111_001111;

    typedef struct {
        string       tag;
        logic [11:0] lvl;
        logic [11:0] prs;
    } frame_exp_t;

    logic       clk = 1'b0;
    logic       rst_l;
    int         n_checks = 0;
    int         n_pass   = 0;
    frame_exp_t sb[$];
    frame_exp_t got_exp;

    player_input_conditioner_if #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .NUM_BUTTONS(NUM_BUTTONS)
    ) ifc ();

    player_input_conditioner #(
        .NUM_PLAYERS    (NUM_PLAYERS),
        .NUM_BUTTONS    (NUM_BUTTONS),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW_MASK(6'b001111)
    ) dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected snapshot is queued when the tick is driven; the monitor pops it.
    task automatic do_frame(input string tag, input logic [11:0] lvl, input logic [11:0] prs);
        frame_exp_t e;
        e.tag = tag;
        e.lvl = lvl;
        e.prs = prs;
        sb.push_back(e);
        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        check({tag, "_valid_hi"}, 32'(ifc.frame_valid), 32'd1);
        step();
        check({tag, "_valid_lo"}, 32'(ifc.frame_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_l === 1'b1 && ifc.frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                got_exp = sb.pop_front();
                check({got_exp.tag, "_flvl"}, 32'(ifc.frame_level), 32'(got_exp.lvl));
                check({got_exp.tag, "_fprs"}, 32'(ifc.frame_press), 32'(got_exp.prs));
            end
        end
    end

    initial begin
        rst_l           = 1'b1;
        ifc.raw_buttons = IDLE;
        ifc.frame_tick  = 1'b0;
        #2 rst_l = 1'b0;
        repeat (3) step();
        check("rst_level",  32'(ifc.level),       32'd0);
        check("rst_flevel", 32'(ifc.frame_level), 32'd0);
        check("rst_fpress", 32'(ifc.frame_press), 32'd0);
        check("rst_fvalid", 32'(ifc.frame_valid), 32'd0);
        rst_l = 1'b1;
        repeat (3) step();
        check("idle_level", 32'(ifc.level), 32'd0);

        // P1 left (active-low): level follows at edge 6 after first sample
        ifc.raw_buttons[0] = 1'b0;
        repeat (5) step();
        check("left_lvl_e5", 32'(ifc.level[0]), 32'd0);
        step();
        check("left_lvl_e6", 32'(ifc.level[0]), 32'd1);
        repeat (3) step();
        do_frame("left_press", 12'h001, 12'h001);
        ifc.raw_buttons[0] = 1'b1;
        repeat (8) step();
        check("left_released", 32'(ifc.level), 32'd0);
        do_frame("left_idle", 12'h000, 12'h000);

        // P2 attack glitch of 3 cycles must be rejected
        ifc.raw_buttons[10] = 1'b1;
        repeat (3) begin step(); check("attack_glitch_hi", 32'(ifc.level[10]), 32'd0); end
        ifc.raw_buttons[10] = 1'b0;
        repeat (5) begin step(); check("attack_glitch_lo", 32'(ifc.level[10]), 32'd0); end
        do_frame("attack_glitch", 12'h000, 12'h000);

        // P1 shield tapped and released inside one frame
        ifc.raw_buttons[5] = 1'b1;
        repeat (10) step();
        check("shield_held", 32'(ifc.level[5]), 32'd1);
        ifc.raw_buttons[5] = 1'b0;
        repeat (10) step();
        check("shield_rel", 32'(ifc.level[5]), 32'd0);
        do_frame("shield_tap", 12'h000, 12'h020);
        repeat (4) step();
        do_frame("shield_after", 12'h000, 12'h000);

        // P2 up (bit 8) rises on the very edge that closes the frame
        ifc.raw_buttons[8] = 1'b0;
        repeat (5) step();
        check("up_lvl_e5", 32'(ifc.level[8]), 32'd0);
        sb.push_back('{tag: "up_same_edge", lvl: 12'h100, prs: 12'h100});
        ifc.frame_tick = 1'b1;
        step();
        ifc.frame_tick = 1'b0;
        check("up_lvl_e6", 32'(ifc.level[8]), 32'd1);
        check("up_valid_hi", 32'(ifc.frame_valid), 32'd1);
        step();
        check("up_valid_lo", 32'(ifc.frame_valid), 32'd0);
        repeat (3) step();
        do_frame("up_hold", 12'h100, 12'h000);
        ifc.raw_buttons[8] = 1'b1;
        repeat (8) step();
        do_frame("up_release", 12'h000, 12'h000);

        // Reset two cycles after a rise, before the frame closes
        ifc.raw_buttons[0] = 1'b0;
        repeat (8) step();
        do_frame("left2", 12'h001, 12'h001);
        ifc.raw_buttons[5] = 1'b1;
        repeat (6) step();
        check("shield2_rise", 32'(ifc.level[5]), 32'd1);
        repeat (2) step();
        rst_l = 1'b0;
        #1;
        check("async_level",  32'(ifc.level),       32'd0);
        check("async_flevel", 32'(ifc.frame_level), 32'd0);
        check("async_fpress", 32'(ifc.frame_press), 32'd0);
        check("async_fvalid", 32'(ifc.frame_valid), 32'd0);
        ifc.raw_buttons = IDLE;
        repeat (2) step();
        rst_l = 1'b1;
        repeat (8) step();
        check("post_rst_level", 32'(ifc.level), 32'd0);
        do_frame("post_reset", 12'h000, 12'h000);

        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
